// File: rtl/quick_uart_tx_fifo_if.sv
// quick_uart_tx_fifo_if
// Bus-side bundle for the buffered UART transmitter. It carries the producer
// handshake, the per-frame line configuration and the status/line outputs.
//   master : producer side (drives valid/data/config, observes status/line)
//   slave  : transmitter side
// Signals:
//   valid_i/data_i/ready_o : write handshake into the FIFO
//   div_i/parity_i/stop2_i : baud divisor, parity mode, two-stop select
//   busy_o/level_o/tx_o    : frame in flight, FIFO occupancy, serial line
interface quick_uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 valid_i;
  logic [DATA_BITS-1:0] data_i;
  logic                 ready_o;
  logic [DIV_WIDTH-1:0] div_i;
  logic [1:0]           parity_i;
  logic                 stop2_i;
  logic                 busy_o;
  logic [LW-1:0]        level_o;
  logic                 tx_o;

  modport master (
    output valid_i, data_i, div_i, parity_i, stop2_i,
    input  ready_o, busy_o, level_o, tx_o
  );

  modport slave (
    input  valid_i, data_i, div_i, parity_i, stop2_i,
    output ready_o, busy_o, level_o, tx_o
  );
endinterface

// File: rtl/quick_uart_tx_fifo.sv
// quick_uart_tx_fifo
// Buffered UART transmitter. A FIFO decouples the producer from the line; a
// five-state FSM pops the FIFO head and serialises start, data (LSB first),
// optional parity and 1/2 stop bits. Frames run back-to-back while data
// remains. Divisor, parity and stop selection are latched at frame launch.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset (flushes FIFO, idles the line)
//   bus   : quick_uart_tx_fifo_if.slave (handshake, config, status, tx_o)
module quick_uart_tx_fifo #(
  parameter int   DATA_BITS  = 8,
  parameter int   FIFO_DEPTH = 16,
  parameter int   DIV_WIDTH  = 16,
  parameter logic IDLE_VALUE = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  quick_uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit over the data word; odd mode inverts the even result.
  function automatic logic f_parity(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]        r_level;

  state_t               r_state, w_state_nx;
  logic [DIV_WIDTH-1:0] r_timer, w_timer_nx;
  logic [DIV_WIDTH-1:0] r_div, w_div_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic [BW-1:0]        r_bit_cnt, w_bit_cnt_nx;
  logic                 r_par_en, w_par_en_nx;
  logic                 r_par_bit, w_par_bit_nx;
  logic                 r_stop2, w_stop2_nx;
  logic                 r_stop_cnt, w_stop_cnt_nx;
  logic                 r_tx, w_tx_nx;
  logic                 r_busy, w_busy_nx;

  logic                 w_push, w_pop, w_launch, w_ready, w_empty, w_tick;
  logic [DIV_WIDTH-1:0] w_div_eff;
  logic [DATA_BITS-1:0] w_head;

  assign w_ready   = (r_level != LW'(FIFO_DEPTH));
  assign w_empty   = (r_level == {LW{1'b0}});
  assign w_push    = bus.valid_i & w_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_tick    = (r_timer == {DIV_WIDTH{1'b0}});
  // A divisor of zero behaves as one cycle per bit.
  assign w_div_eff = (bus.div_i == {DIV_WIDTH{1'b0}}) ? DIV_WIDTH'(1) : bus.div_i;

  assign bus.ready_o = w_ready;
  assign bus.level_o = r_level;
  assign bus.busy_o  = r_busy;
  assign bus.tx_o    = r_tx;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.data_i;
    end
  end

  // FIFO pointers and occupancy; push+pop on one edge leaves the level alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FSM next state, bit timer, shifter and registered line level.
  always_comb begin
    w_state_nx    = r_state;
    w_timer_nx    = w_tick ? (r_div - DIV_WIDTH'(1)) : (r_timer - DIV_WIDTH'(1));
    w_div_nx      = r_div;
    w_shift_nx    = r_shift;
    w_bit_cnt_nx  = r_bit_cnt;
    w_par_en_nx   = r_par_en;
    w_par_bit_nx  = r_par_bit;
    w_stop2_nx    = r_stop2;
    w_stop_cnt_nx = r_stop_cnt;
    w_tx_nx       = r_tx;
    w_busy_nx     = r_busy;
    w_launch      = 1'b0;
    w_pop         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer_nx = r_timer;
        if (!w_empty) begin
          w_launch = 1'b1;
        end else begin
          w_tx_nx   = IDLE_VALUE;
          w_busy_nx = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nx   = S_DATA;
          w_tx_nx      = r_shift[0];
          w_shift_nx   = r_shift >> 1;
          w_bit_cnt_nx = {BW{1'b0}};
        end else begin
          w_state_nx = S_START;
        end
      end
      S_DATA: begin
        if (w_tick && (r_bit_cnt == BW'(DATA_BITS - 1))) begin
          w_state_nx    = r_par_en ? S_PARITY : S_STOP;
          w_tx_nx       = r_par_en ? r_par_bit : IDLE_VALUE;
          w_stop_cnt_nx = 1'b0;
        end else if (w_tick) begin
          w_tx_nx      = r_shift[0];
          w_shift_nx   = r_shift >> 1;
          w_bit_cnt_nx = r_bit_cnt + BW'(1);
        end else begin
          w_state_nx = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nx    = S_STOP;
          w_tx_nx       = IDLE_VALUE;
          w_stop_cnt_nx = 1'b0;
        end else begin
          w_state_nx = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_tick && r_stop2 && !r_stop_cnt) begin
          w_stop_cnt_nx = 1'b1;
        end else if (w_tick && !w_empty) begin
          // Next start bit begins on the edge this stop period ends.
          w_launch = 1'b1;
        end else if (w_tick) begin
          w_state_nx = S_IDLE;
          w_tx_nx    = IDLE_VALUE;
          w_busy_nx  = 1'b0;
        end else begin
          w_state_nx = S_STOP;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_tx_nx    = IDLE_VALUE;
        w_busy_nx  = 1'b0;
      end
    endcase

    // Frame launch: pop the head and latch this frame's configuration.
    if (w_launch) begin
      w_pop        = 1'b1;
      w_state_nx   = S_START;
      w_tx_nx      = ~IDLE_VALUE;
      w_busy_nx    = 1'b1;
      w_shift_nx   = w_head;
      w_div_nx     = w_div_eff;
      w_timer_nx   = w_div_eff - DIV_WIDTH'(1);
      w_par_en_nx  = (bus.parity_i == 2'd1) || (bus.parity_i == 2'd2);
      w_par_bit_nx = f_parity(w_head, bus.parity_i == 2'd2);
      w_stop2_nx   = bus.stop2_i;
    end else begin
      w_pop = 1'b0;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_timer    <= {DIV_WIDTH{1'b0}};
      r_div      <= DIV_WIDTH'(1);
      r_shift    <= {DATA_BITS{1'b0}};
      r_bit_cnt  <= {BW{1'b0}};
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_tx       <= IDLE_VALUE;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_timer    <= w_timer_nx;
      r_div      <= w_div_nx;
      r_shift    <= w_shift_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_par_en   <= w_par_en_nx;
      r_par_bit  <= w_par_bit_nx;
      r_stop2    <= w_stop2_nx;
      r_stop_cnt <= w_stop_cnt_nx;
      r_tx       <= w_tx_nx;
      r_busy     <= w_busy_nx;
    end
  end
endmodule

// File: tb/tb_quick_uart_tx_fifo.sv
// tb_quick_uart_tx_fifo
// Directed bench for quick_uart_tx_fifo. A sampler records tx_o/busy_o 1 ns
// after every rising edge into arrays indexed by cycle; frames are decoded
// from those records and compared with hand-computed bit patterns. Pattern
// bit 0 is the first bit on the line (start bit), last bit is the final stop.
module tb_quick_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic smp_tx   [0:32767];
  logic smp_busy [0:32767];

  always #5 clk = ~clk;

  quick_uart_tx_fifo_if u_if ();

  quick_uart_tx_fifo u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if)
  );

  // Record line and busy just after each active edge; index = edge number.
  always @(posedge clk) begin
    #1;
    if (cyc < 32768) begin
      smp_tx[cyc]   = u_if.tx_o;
      smp_busy[cyc] = u_if.busy_o;
    end
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Collect nbits bit levels starting at sample 'start'; count samples that
  // differ from the first sample of their bit period.
  task automatic decode(input int start, input int div, input int nbits,
                        output logic [31:0] val, output int bad);
    val = 32'd0;
    bad = 0;
    for (int b = 0; b < nbits; b++) begin
      val[b] = smp_tx[start + b * div];
      for (int k = 1; k < div; k++) begin
        if (smp_tx[start + b * div + k] !== smp_tx[start + b * div]) bad++;
      end
    end
  endtask

  function automatic int busy_run(input int start);
    int n = 0;
    while ((start + n) < 32768 && smp_busy[start + n] === 1'b1 && n < 30000) n++;
    return n;
  endfunction

  // Single push: valid set at a negedge (c = cycle index of the accepting edge).
  task automatic push(input logic [7:0] d, output int c);
    @(negedge clk);
    c = cyc;
    u_if.valid_i = 1'b1;
    u_if.data_i  = d;
    @(negedge clk);
    u_if.valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((u_if.busy_o !== 1'b0 || u_if.level_o !== 5'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int          c;
    int          bad;
    int          bad_sum;
    int          zeros;
    int          highs;
    logic [31:0] v;
    logic [7:0]  d;

    u_if.valid_i  = 1'b0;
    u_if.data_i   = 8'h00;
    u_if.div_i    = 16'd4;
    u_if.parity_i = 2'd0;
    u_if.stop2_i  = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_tx",    32'(u_if.tx_o),    32'd1);
    check("rst_busy",  32'(u_if.busy_o),  32'd0);
    check("rst_level", 32'(u_if.level_o), 32'd0);
    check("rst_ready", 32'(u_if.ready_o), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame 0xA5, div 4, no parity, one stop.
    push(8'hA5, c);
    check("a5_level_after_push", 32'(u_if.level_o), 32'd1);
    check("a5_tx_before_launch", 32'(u_if.tx_o), 32'd1);
    @(negedge clk);
    check("a5_launch_tx",    32'(u_if.tx_o),    32'd0);
    check("a5_launch_busy",  32'(u_if.busy_o),  32'd1);
    check("a5_launch_level", 32'(u_if.level_o), 32'd0);
    wait_idle("a5_done", 200);
    decode(c + 1, 4, 10, v, bad);
    check("a5_frame",    v, 32'h34A);
    check("a5_uniform",  32'(bad), 32'd0);
    check("a5_busy_len", 32'(busy_run(c + 1)), 32'd40);

    // Even parity, 0x07: parity bit 1.
    u_if.parity_i = 2'd1;
    push(8'h07, c);
    wait_idle("even_done", 200);
    decode(c + 1, 4, 11, v, bad);
    check("even_frame",    v, 32'h60E);
    check("even_uniform",  32'(bad), 32'd0);
    check("even_busy_len", 32'(busy_run(c + 1)), 32'd44);

    // Odd parity, 0x07: parity bit 0.
    u_if.parity_i = 2'd2;
    push(8'h07, c);
    wait_idle("odd_done", 200);
    decode(c + 1, 4, 11, v, bad);
    check("odd_frame",   v, 32'h40E);
    check("odd_uniform", 32'(bad), 32'd0);

    // div 3, even parity, two stops: 12 bits, 36 cycles.
    u_if.div_i    = 16'd3;
    u_if.parity_i = 2'd1;
    u_if.stop2_i  = 1'b1;
    push(8'h07, c);
    wait_idle("stop2_done", 200);
    decode(c + 1, 3, 12, v, bad);
    check("stop2_frame",    v, 32'hE0E);
    check("stop2_uniform",  32'(bad), 32'd0);
    check("stop2_busy_len", 32'(busy_run(c + 1)), 32'd36);

    // Mid-frame divisor change: first frame keeps 4, second uses 8.
    u_if.div_i    = 16'd4;
    u_if.parity_i = 2'd0;
    u_if.stop2_i  = 1'b0;
    @(negedge clk);
    c = cyc;
    u_if.valid_i = 1'b1;
    u_if.data_i  = 8'h5A;
    @(negedge clk);
    u_if.data_i  = 8'hC3;
    @(negedge clk);
    u_if.valid_i = 1'b0;
    repeat (10) @(negedge clk);
    u_if.div_i = 16'd8;
    wait_idle("cfg_done", 400);
    decode(c + 1, 4, 10, v, bad);
    check("cfg_frame1",   v, 32'h2B4);
    check("cfg_uniform1", 32'(bad), 32'd0);
    decode(c + 41, 8, 10, v, bad);
    check("cfg_frame2",   v, 32'h386);
    check("cfg_uniform2", 32'(bad), 32'd0);
    check("cfg_busy_len", 32'(busy_run(c + 1)), 32'd120);

    // Reset mid-frame with three words queued.
    u_if.div_i = 16'd4;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      u_if.valid_i = 1'b1;
      u_if.data_i  = 8'h00;
      @(negedge clk);
    end
    u_if.valid_i = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_pre_tx",    32'(u_if.tx_o),    32'd0);
    check("rstmid_pre_level", 32'(u_if.level_o), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_tx",    32'(u_if.tx_o),    32'd1);
    check("rstmid_level", 32'(u_if.level_o), 32'd0);
    check("rstmid_busy",  32'(u_if.busy_o),  32'd0);
    check("rstmid_ready", 32'(u_if.ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    repeat (60) @(negedge clk);
    zeros = 0;
    highs = 0;
    for (int i = 0; i < 58; i++) begin
      if (smp_tx[c + i] !== 1'b1) zeros++;
      if (smp_busy[c + i] !== 1'b0) highs++;
    end
    check("rstmid_quiet_tx",   32'(zeros), 32'd0);
    check("rstmid_quiet_busy", 32'(highs), 32'd0);

    // Minimum divisor: 0 behaves as 1.
    u_if.div_i = 16'd0;
    push(8'hFF, c);
    wait_idle("div0_done", 100);
    decode(c + 1, 1, 10, v, bad);
    check("div0_frame",    v, 32'h3FE);
    check("div0_busy_len", 32'(busy_run(c + 1)), 32'd10);
    u_if.div_i = 16'd1;
    push(8'hFF, c);
    wait_idle("div1_done", 100);
    decode(c + 1, 1, 10, v, bad);
    check("div1_frame",    v, 32'h3FE);
    check("div1_busy_len", 32'(busy_run(c + 1)), 32'd10);

    // Fill and overflow, div 100: 17 accepted, 18th dropped.
    u_if.div_i = 16'd100;
    @(negedge clk);
    c = cyc;
    for (int k = 0; k < 18; k++) begin
      u_if.valid_i = 1'b1;
      u_if.data_i  = 8'h30 + 8'(k);
      @(negedge clk);
      if (k == 15) check("fill_ready_16", 32'(u_if.ready_o), 32'd1);
      if (k == 16) check("fill_ready_17", 32'(u_if.ready_o), 32'd0);
    end
    u_if.valid_i = 1'b0;
    check("fill_level_after_drop", 32'(u_if.level_o), 32'd16);
    wait_idle("fill_done", 20000);
    bad_sum = 0;
    for (int k = 0; k < 17; k++) begin
      d = 8'h30 + 8'(k);
      decode(c + 1 + k * 1000, 100, 10, v, bad);
      bad_sum += bad;
      check($sformatf("fill_frame_%0d", k), v, {22'd0, 1'b1, d, 1'b0});
    end
    check("fill_uniform",  32'(bad_sum), 32'd0);
    check("fill_busy_len", 32'(busy_run(c + 1)), 32'd17000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
